// File: rtl/dvp_pattern_tx_pkg.sv
// dvp_pattern_tx_pkg: mode encodings, bar colours and FSM states for the DVP pattern transmitter
package dvp_pattern_tx_pkg;
  localparam logic [1:0] MODE_BARS = 2'd0;
  localparam logic [1:0] MODE_GRAD = 2'd1;
  localparam logic [1:0] MODE_SOLID = 2'd2;
  // index 0 is the leftmost bar
  localparam logic [7:0][15:0] BAR_RGB = {
    16'h0000, 16'h001F, 16'hF800, 16'hF81F, 16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF
  };
  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_VFRONT} state_t;
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a > b ? a : b;
    m = c > m ? c : m;
    return d > m ? d : m;
  endfunction
endpackage

// File: rtl/dvp_pattern_gen.sv
// dvp_pattern_gen: combinational RGB565 test-pattern pixel for a given position and latched mode
module dvp_pattern_gen
  import dvp_pattern_tx_pkg::*;
(
  input  logic [2:0]  bar,
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  input  logic [7:0]  fcnt,
  input  logic [1:0]  mode,
  input  logic [15:0] solid,
  output logic [15:0] rgb
);
  always_comb rgb = mode >= MODE_SOLID ? solid : mode == MODE_GRAD ? {x + fcnt, y} : BAR_RGB[bar];
endmodule

// File: rtl/dvp_pattern_tx.sv
// dvp_pattern_tx: OV5640-style 8-bit DVP frame generator driven by an internal RGB565 test pattern
module dvp_pattern_tx
  import dvp_pattern_tx_pkg::*;
#(
  parameter int H_ACTIVE    = 800,
  parameter int H_BLANK     = 64,
  parameter int V_ACTIVE    = 480,
  parameter int VSYNC_LINES = 2,
  parameter int V_BACK      = 8,
  parameter int V_FRONT     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [15:0] solid_rgb,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  db,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);
  localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
  localparam int BCW = $clog2(LINE_LEN);
  localparam int LCW = $clog2(max4(VSYNC_LINES, V_BACK, V_ACTIVE, V_FRONT)) + 1;
  localparam int BW = H_ACTIVE / 8 > 0 ? H_ACTIVE / 8 : 1;
  localparam int RW = $clog2(BW) + 1;
  state_t state, state_n, after;
  logic [BCW-1:0] bcnt, bcnt_n;
  logic [LCW-1:0] lcnt, lcnt_n, span;
  logic [2:0] bar, bar_n;
  logic [RW-1:0] brem, brem_n;
  logic [1:0] mode_l;
  logic [15:0] solid_l, pix;
  logic line_end, last_line, start, href_n;
  // Outputs are registered from next-state values so they line up with the counters.
  always_comb begin
    line_end = bcnt == BCW'(LINE_LEN - 1);
    span = state == S_VSYNC ? LCW'(VSYNC_LINES) : state == S_VBACK ? LCW'(V_BACK) :
           state == S_ACTIVE ? LCW'(V_ACTIVE) : LCW'(V_FRONT);
    last_line = line_end && lcnt == span - 1'b1;
    after = state == S_VSYNC ? (V_BACK > 0 ? S_VBACK : S_ACTIVE) :
            state == S_VBACK ? S_ACTIVE :
            state == S_ACTIVE && V_FRONT > 0 ? S_VFRONT :
            enable ? S_VSYNC : S_IDLE;
    state_n = state == S_IDLE ? (enable ? S_VSYNC : S_IDLE) : last_line ? after : state;
    bcnt_n = state == S_IDLE || line_end ? '0 : bcnt + 1'b1;
    lcnt_n = state == S_IDLE || last_line ? '0 : line_end ? lcnt + 1'b1 : lcnt;
    start = state_n == S_VSYNC && state != S_VSYNC;
    href_n = state_n == S_ACTIVE && {1'b0, bcnt_n} < (BCW + 1)'(2 * H_ACTIVE);
    bar_n = bcnt_n == '0 ? '0 : bcnt_n[0] || brem != '0 || bar == 3'd7 ? bar : bar + 3'd1;
    brem_n = bcnt_n == '0 ? RW'(BW - 1) : bcnt_n[0] ? brem : brem == '0 ? RW'(BW - 1) : brem - 1'b1;
  end
  dvp_pattern_gen u_gen (
    .bar  (bar_n),
    .x    (8'(bcnt_n >> 1)),
    .y    (8'(lcnt_n)),
    .fcnt (frame_cnt[7:0]),
    .mode (mode_l),
    .solid(solid_l),
    .rgb  (pix)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      bcnt        <= '0;
      lcnt        <= '0;
      bar         <= '0;
      brem        <= '0;
      mode_l      <= MODE_BARS;
      solid_l     <= '0;
      vsync       <= 1'b0;
      href        <= 1'b0;
      db          <= 8'h00;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      state       <= state_n;
      bcnt        <= bcnt_n;
      lcnt        <= lcnt_n;
      bar         <= bar_n;
      brem        <= brem_n;
      mode_l      <= start ? mode : mode_l;
      solid_l     <= start ? solid_rgb : solid_l;
      vsync       <= state_n == S_VSYNC;
      href        <= href_n;
      db          <= href_n ? (bcnt_n[0] ? pix[7:0] : pix[15:8]) : 8'h00;
      frame_start <= start;
      frame_cnt   <= frame_cnt + 16'(start);
    end
  end
endmodule
